// File: rtl/cc_stream_crypt_if.sv
// Plaintext-in / ciphertext-out valid/ready bundle for cc_stream_crypt.
// slave is the engine's view, master is the feeding/consuming side.
interface cc_stream_crypt_if;
  logic         i_pt_valid;
  logic [511:0] i_pt;
  logic         o_pt_ready;
  logic         o_ct_valid;
  logic [511:0] o_ct;
  logic [63:0]  o_ct_keep;
  logic         o_ct_last;
  logic         i_ct_ready;

  modport slave (
    input  i_pt_valid, i_pt, i_ct_ready,
    output o_pt_ready, o_ct_valid, o_ct, o_ct_keep, o_ct_last
  );

  modport master (
    output i_pt_valid, i_pt, i_ct_ready,
    input  o_pt_ready, o_ct_valid, o_ct, o_ct_keep, o_ct_last
  );
endinterface

// File: rtl/cc_stream_crypt.sv
// ChaCha20 stream encryption: N_CORE keystream cores per round, ct registered 1 cycle after pt accept.
// pt is accepted only while the ct register is empty or draining; o_ct holds while valid && !ready.

// One ChaCha20 block per start: one double round per cycle, result held until the next start.
module cc_block (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_start,
  input  logic [255:0] i_key,
  input  logic [95:0]  i_non,
  input  logic [31:0]  i_cnt,
  output logic         o_done,
  output logic [511:0] o_blk
);
  logic [31:0] init_w [16];
  logic [31:0] init_q [16];
  logic [31:0] x_q    [16];
  logic [31:0] col_w  [16];
  logic [31:0] dia_w  [16];
  logic [3:0]  rnd_q;
  logic        run_q;

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [127:0] qr(input logic [31:0] a_i, input logic [31:0] b_i,
                                      input logic [31:0] c_i, input logic [31:0] d_i);
    logic [31:0] a, b, c, d;
    a = a_i; b = b_i; c = c_i; d = d_i;
    a = a + b; d = rotl(d ^ a, 16);
    c = c + d; b = rotl(b ^ c, 12);
    a = a + b; d = rotl(d ^ a, 8);
    c = c + d; b = rotl(b ^ c, 7);
    return {a, b, c, d};
  endfunction

  always_comb begin
    init_w[0]  = 32'h61707865;
    init_w[1]  = 32'h3320646e;
    init_w[2]  = 32'h79622d32;
    init_w[3]  = 32'h6b206574;
    for (int i = 0; i < 8; i++) init_w[4+i] = i_key[32*i +: 32];
    init_w[12] = i_cnt;
    for (int i = 0; i < 3; i++) init_w[13+i] = i_non[32*i +: 32];
  end

  // Column round feeds the diagonal round combinationally: one double round per clock.
  always_comb begin
    {col_w[0], col_w[4], col_w[8],  col_w[12]} = qr(x_q[0], x_q[4], x_q[8],  x_q[12]);
    {col_w[1], col_w[5], col_w[9],  col_w[13]} = qr(x_q[1], x_q[5], x_q[9],  x_q[13]);
    {col_w[2], col_w[6], col_w[10], col_w[14]} = qr(x_q[2], x_q[6], x_q[10], x_q[14]);
    {col_w[3], col_w[7], col_w[11], col_w[15]} = qr(x_q[3], x_q[7], x_q[11], x_q[15]);
    {dia_w[0], dia_w[5], dia_w[10], dia_w[15]} = qr(col_w[0], col_w[5], col_w[10], col_w[15]);
    {dia_w[1], dia_w[6], dia_w[11], dia_w[12]} = qr(col_w[1], col_w[6], col_w[11], col_w[12]);
    {dia_w[2], dia_w[7], dia_w[8],  dia_w[13]} = qr(col_w[2], col_w[7], col_w[8],  col_w[13]);
    {dia_w[3], dia_w[4], dia_w[9],  dia_w[14]} = qr(col_w[3], col_w[4], col_w[9],  col_w[14]);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      run_q  <= 1'b0;
      rnd_q  <= 4'd0;
      o_done <= 1'b0;
      o_blk  <= '0;
      for (int i = 0; i < 16; i++) begin
        x_q[i]    <= '0;
        init_q[i] <= '0;
      end
    end else begin
      o_done <= 1'b0;
      if (i_start) begin
        run_q <= 1'b1;
        rnd_q <= 4'd0;
        for (int i = 0; i < 16; i++) begin
          x_q[i]    <= init_w[i];
          init_q[i] <= init_w[i];
        end
      end else if (run_q) begin
        rnd_q <= rnd_q + 4'd1;
        for (int i = 0; i < 16; i++) x_q[i] <= dia_w[i];
        if (rnd_q == 4'd9) begin
          run_q  <= 1'b0;
          o_done <= 1'b1;
          for (int i = 0; i < 16; i++) o_blk[32*i +: 32] <= dia_w[i] + init_q[i];
        end
      end
    end
  end
endmodule

module cc_stream_crypt #(
  parameter int N_CORE = 2,
  parameter int CNT_W  = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [255:0]     i_key,
  input  logic [95:0]      i_non,
  input  logic [CNT_W-1:0] i_cnt0,
  input  logic [31:0]      i_len,
  cc_stream_crypt_if.slave bus,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);
  typedef enum logic [2:0] {
    ST_IDLE, ST_GEN, ST_WAIT, ST_XOR, ST_DRAIN, ST_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [255:0]       key_q;
  logic [95:0]        non_q;
  logic [5:0]         tail_q;
  logic [31:0]        rem_q;
  logic [CNT_W-1:0]   base_q;
  logic [3:0]         slot_q, rcnt_q, r_now;
  logic [N_CORE-1:0]  used_q, seen_q, seen_nxt, core_go, core_done;
  logic [511:0]       core_blk [N_CORE];
  logic [511:0]       ct_q, ks, byte_mask;
  logic [63:0]        keep_q, keep_d;
  logic               vld_q, last_q, err_q;
  logic [CNT_W:0]     nblk, cnt_end;
  logic               start_ok, start_bad, all_seen, pt_rdy, pt_hs, ct_hs, slot_end, is_last;

  // 33-bit arithmetic so a message ending exactly at counter 2^32-1 is still accepted.
  assign nblk      = ({1'b0, i_len} + 33'd63) >> 6;
  assign cnt_end   = {1'b0, i_cnt0} + nblk;
  assign start_ok  = (state_q == ST_IDLE) && i_start && (cnt_end <= 33'h1_0000_0000);
  assign start_bad = (state_q == ST_IDLE) && i_start && (cnt_end >  33'h1_0000_0000);

  assign r_now    = (rem_q < 32'(N_CORE)) ? rem_q[3:0] : 4'(N_CORE);
  assign seen_nxt = seen_q | core_done;
  assign all_seen = ((seen_nxt & used_q) == used_q);
  assign pt_rdy   = (state_q == ST_XOR) && (!vld_q || bus.i_ct_ready);
  assign pt_hs    = pt_rdy && bus.i_pt_valid;
  assign ct_hs    = vld_q && bus.i_ct_ready;
  assign slot_end = (slot_q == rcnt_q - 4'd1);
  assign is_last  = (rem_q == 32'd1);
  assign keep_d   = (is_last && tail_q != 6'd0) ? ((64'd1 << tail_q) - 64'd1) : '1;

  always_comb begin
    core_go = '0;
    for (int k = 0; k < N_CORE; k++) core_go[k] = (state_q == ST_GEN) && (4'(k) < r_now);
  end

  always_comb begin
    ks = '0;
    for (int k = 0; k < N_CORE; k++) if (slot_q == 4'(k)) ks = core_blk[k];
  end

  always_comb begin
    byte_mask = '0;
    for (int i = 0; i < 64; i++) byte_mask[8*i +: 8] = {8{keep_d[i]}};
  end

  for (genvar k = 0; k < N_CORE; k++) begin : g_core
    cc_block u_core (
      .i_clk   (i_clk),
      .i_rstn  (~i_rst),
      .i_start (core_go[k]),
      .i_key   (key_q),
      .i_non   (non_q),
      .i_cnt   (base_q + CNT_W'(k)),
      .o_done  (core_done[k]),
      .o_blk   (core_blk[k])
    );
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_ok) state_d = (nblk == '0) ? ST_DONE : ST_GEN;
      ST_GEN:   state_d = ST_WAIT;
      ST_WAIT:  if (all_seen) state_d = ST_XOR;
      ST_XOR:   if (pt_hs && slot_end) state_d = (rem_q > 32'd1) ? ST_GEN : ST_DRAIN;
      ST_DRAIN: if (ct_hs) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      key_q  <= '0;
      non_q  <= '0;
      tail_q <= '0;
      rem_q  <= '0;
      base_q <= '0;
      slot_q <= '0;
      rcnt_q <= '0;
      used_q <= '0;
      seen_q <= '0;
      ct_q   <= '0;
      keep_q <= '0;
      last_q <= 1'b0;
      vld_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      err_q <= start_bad;
      if (start_ok) begin
        key_q  <= i_key;
        non_q  <= i_non;
        tail_q <= i_len[5:0];
        rem_q  <= nblk[31:0];
        base_q <= i_cnt0;
      end
      if (state_q == ST_GEN) begin
        rcnt_q <= r_now;
        slot_q <= '0;
        used_q <= core_go;
        seen_q <= '0;
      end else if (state_q == ST_WAIT) begin
        seen_q <= seen_nxt;
      end
      // A new beat may replace the one leaving in the same cycle, so valid stays high.
      if (pt_hs) begin
        ct_q   <= (bus.i_pt ^ ks) & byte_mask;
        keep_q <= keep_d;
        last_q <= is_last;
        vld_q  <= 1'b1;
        slot_q <= slot_q + 4'd1;
        rem_q  <= rem_q - 32'd1;
        base_q <= base_q + 1'b1;
      end else if (ct_hs) begin
        vld_q <= 1'b0;
      end
    end
  end

  assign bus.o_pt_ready = pt_rdy;
  assign bus.o_ct_valid = vld_q;
  assign bus.o_ct       = ct_q;
  assign bus.o_ct_keep  = keep_q;
  assign bus.o_ct_last  = last_q;
  assign o_busy         = (state_q != ST_IDLE);
  assign o_done         = (state_q == ST_DONE);
  assign o_err          = err_q;
endmodule

// File: tb/tb_cc_stream_crypt.sv
// Randomised scoreboard bench for cc_stream_crypt against a plain ChaCha20 reference.
module tb_cc_stream_crypt;
  localparam int NC = 2;

  typedef struct packed {
    logic [511:0] ct;
    logic [63:0]  keep;
    logic         last;
  } beat_t;

  logic         i_clk, i_rst, i_start;
  logic [255:0] i_key;
  logic [95:0]  i_non;
  logic [31:0]  i_cnt0, i_len;
  logic         o_busy, o_done, o_err;

  cc_stream_crypt_if bus();

  cc_stream_crypt #(.N_CORE(NC), .CNT_W(32)) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_start(i_start),
    .i_key  (i_key),
    .i_non  (i_non),
    .i_cnt0 (i_cnt0),
    .i_len  (i_len),
    .bus    (bus),
    .o_busy (o_busy),
    .o_done (o_done),
    .o_err  (o_err)
  );

  int           total = 0;
  int           bad = 0;
  bit           rnd_mode = 0;
  beat_t        sb[$];
  logic [511:0] got_log[$];
  logic [511:0] msg_blk [16];

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  // RFC 8439 block function written directly from the quarter-round definition.
  function automatic logic [511:0] ref_block(input logic [255:0] k, input logic [95:0] n,
                                             input logic [31:0] c);
    logic [31:0]  s [16];
    logic [31:0]  x [16];
    logic [511:0] r;
    int a, b, cc, d;
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4+i] = k[32*i +: 32];
    s[12] = c;
    for (int i = 0; i < 3; i++) s[13+i] = n[32*i +: 32];
    for (int i = 0; i < 16; i++) x[i] = s[i];
    for (int rd = 0; rd < 20; rd++) begin
      for (int q = 0; q < 4; q++) begin
        a = q;
        if (rd % 2 == 0) begin b = 4 + q; cc = 8 + q; d = 12 + q; end
        else begin b = 4 + (q + 1) % 4; cc = 8 + (q + 2) % 4; d = 12 + (q + 3) % 4; end
        x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 16);
        x[cc] = x[cc] + x[d]; x[b] = rotl(x[b] ^ x[cc], 12);
        x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 8);
        x[cc] = x[cc] + x[d]; x[b] = rotl(x[b] ^ x[cc], 7);
      end
    end
    for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i] + s[i];
    return r;
  endfunction

  task automatic fill_rand();
    for (int b = 0; b < 16; b++)
      for (int w = 0; w < 16; w++) msg_blk[b][32*w +: 32] = $urandom;
  endtask

  task automatic start_msg(input logic [255:0] k, input logic [95:0] n,
                           input logic [31:0] c0, input logic [31:0] len);
    i_key = k; i_non = n; i_cnt0 = c0; i_len = len; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
  endtask

  task automatic send_pt(input logic [511:0] blk);
    bit hs;
    int budget;
    hs = 0; budget = 0;
    while (rnd_mode && $urandom_range(0, 2) == 0) begin @(posedge i_clk); #1; end
    bus.i_pt = blk;
    bus.i_pt_valid = 1'b1;
    while (!hs && budget < 2000) begin
      @(negedge i_clk);
      hs = bus.o_pt_ready;
      @(posedge i_clk); #1;
      budget++;
    end
    bus.i_pt_valid = 1'b0;
    if (!hs) begin total++; bad++; $display("FAIL pt_accept_timeout got=0 exp=1"); end
  endtask

  task automatic wait_done();
    bit seen;
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge i_clk);
      if (o_done) seen = 1;
    end
    chk("done_seen", 512'(seen), 512'(1));
    @(posedge i_clk); #1;
  endtask

  task automatic run_msg(input logic [255:0] k, input logic [95:0] n,
                         input logic [31:0] c0, input logic [31:0] len);
    int nb, lr;
    beat_t e;
    logic [511:0] ks;
    bit inb;
    nb = (int'(len) + 63) / 64;
    lr = int'(len) % 64;
    got_log.delete();
    for (int b = 0; b < nb; b++) begin
      ks = ref_block(k, n, c0 + 32'(b));
      for (int i = 0; i < 64; i++) begin
        inb = (b < nb - 1) || (lr == 0) || (i < lr);
        e.keep[i] = inb;
        e.ct[8*i +: 8] = inb ? (msg_blk[b][8*i +: 8] ^ ks[8*i +: 8]) : 8'h00;
      end
      e.last = (b == nb - 1);
      sb.push_back(e);
    end
    start_msg(k, n, c0, len);
    for (int b = 0; b < nb; b++) send_pt(msg_blk[b]);
    wait_done();
    chk("sb_drained", 512'(sb.size()), 512'(0));
    chk("beat_count", 512'(got_log.size()), 512'(nb));
  endtask

  // ct_ready driver
  initial begin
    bus.i_ct_ready = 1'b0;
    forever begin
      @(posedge i_clk); #1;
      bus.i_ct_ready = rnd_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every ct handshake and checks hold behaviour.
  initial begin : monitor
    bit hold_v, done_exp;
    logic [511:0] hold_ct;
    beat_t e;
    hold_v = 0; done_exp = 0; hold_ct = '0;
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        hold_v = 0; done_exp = 0;
      end else begin
        if (done_exp) begin
          chk("done_after_last", 512'(o_done), 512'(1));
          done_exp = 0;
        end
        if (hold_v) begin
          chk("ct_hold_valid", 512'(bus.o_ct_valid), 512'(1));
          chk("ct_hold_data", bus.o_ct, hold_ct);
        end
        hold_v = bus.o_ct_valid && !bus.i_ct_ready;
        hold_ct = bus.o_ct;
        if (bus.o_ct_valid && bus.i_ct_ready) begin
          got_log.push_back(bus.o_ct);
          if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_beat got=%h exp=none", bus.o_ct);
          end else begin
            e = sb.pop_front();
            chk("ct_data", bus.o_ct, e.ct);
            chk("ct_keep", 512'(bus.o_ct_keep), 512'(e.keep));
            chk("ct_last", 512'(bus.o_ct_last), 512'(e.last));
          end
          if (bus.o_ct_last) done_exp = 1;
        end
      end
    end
  end

  initial begin : main
    string        s;
    logic [255:0] k;
    logic [95:0]  n;
    logic [127:0] rfc_head;
    rfc_head = 128'h81690ddd2807ba4180f968259a352e6e;
    i_rst = 1'b1; i_start = 1'b0; i_key = '0; i_non = '0; i_cnt0 = '0; i_len = '0;
    bus.i_pt_valid = 1'b0; bus.i_pt = '0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_busy", 512'(o_busy), 512'(0));
    chk("rst_done", 512'(o_done), 512'(0));
    chk("rst_err", 512'(o_err), 512'(0));
    chk("rst_ct_valid", 512'(bus.o_ct_valid), 512'(0));
    chk("rst_pt_ready", 512'(bus.o_pt_ready), 512'(0));
    chk("rst_ct", bus.o_ct, 512'(0));
    chk("rst_keep", 512'(bus.o_ct_keep), 512'(0));
    chk("rst_last", 512'(bus.o_ct_last), 512'(0));
    i_rst = 1'b0;
    @(posedge i_clk); #1;

    // RFC 8439 section 2.4.2 encryption example
    for (int i = 0; i < 32; i++) k[8*i +: 8] = 8'(i);
    n = '0; n[63:56] = 8'h4a;
    s = "Ladies and Gentlemen of the class of '99: If I could offer you only one tip for the future, sunscreen would be it.";
    fill_rand();
    for (int i = 0; i < s.len(); i++) msg_blk[i / 64][8*(i % 64) +: 8] = s[i];
    run_msg(k, n, 32'd1, 32'(s.len()));
    if (got_log.size() > 0) chk("rfc_ct_head", 512'(got_log[0][127:0]), 512'(rfc_head));

    // zero length: straight to DONE
    start_msg(k, n, 32'd1, 32'd0);
    @(negedge i_clk);
    chk("zero_done", 512'(o_done), 512'(1));
    chk("zero_no_ct", 512'(bus.o_ct_valid), 512'(0));
    @(negedge i_clk);
    chk("zero_done_pulse", 512'(o_done), 512'(0));
    chk("zero_idle", 512'(o_busy), 512'(0));
    @(posedge i_clk); #1;

    // 10 full blocks
    k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    n = {$urandom, $urandom, $urandom};
    fill_rand();
    run_msg(k, n, 32'($urandom_range(0, 1000)), 32'd640);

    // counter at the top of the range
    fill_rand();
    run_msg(k, n, 32'hFFFF_FFFF, 32'd64);
    start_msg(k, n, 32'hFFFF_FFFF, 32'd65);
    @(negedge i_clk);
    chk("ovf_err", 512'(o_err), 512'(1));
    chk("ovf_busy", 512'(o_busy), 512'(0));
    @(negedge i_clk);
    chk("ovf_err_pulse", 512'(o_err), 512'(0));
    chk("ovf_still_idle", 512'(o_busy), 512'(0));
    @(posedge i_clk); #1;

    // random handshakes on both sides
    rnd_mode = 1;
    fill_rand();
    run_msg(k, n, 32'($urandom_range(1, 5000)), 32'd300);
    fill_rand();
    run_msg(k, n, 32'($urandom_range(1, 5000)), 32'($urandom_range(1, 700)));
    rnd_mode = 0;

    // reset while the cores are computing
    fill_rand();
    start_msg(k, n, 32'd7, 32'd320);
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    #1;
    chk("abort_busy", 512'(o_busy), 512'(0));
    chk("abort_ct_valid", 512'(bus.o_ct_valid), 512'(0));
    chk("abort_pt_ready", 512'(bus.o_pt_ready), 512'(0));
    chk("abort_done", 512'(o_done), 512'(0));
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    run_msg(k, n, 32'd7, 32'd320);

    repeat (3) @(posedge i_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
